// File: rtl/add_slice_seq.sv
// Multi-cycle WIDTH-bit adder/subtractor: one shared SLICE-bit adder is applied
// LSB slice first, and the carry is held in a register between slices.
module add_slice_seq #(
  parameter int WIDTH = 64,
  parameter int SLICE = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             op_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

  generate
    if (NSLICE < 2 || (WIDTH % SLICE) != 0) begin : g_bad_params
      $error("add_slice_seq: WIDTH must be a multiple of SLICE with WIDTH/SLICE >= 2");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                        state;
  logic [IDXW-1:0]               idx;
  logic                          carry;
  logic [NSLICE-1:0][SLICE-1:0]  a_q;
  logic [NSLICE-1:0][SLICE-1:0]  b_q;
  logic [NSLICE-1:0][SLICE-1:0]  sum_q;
  logic [SLICE:0]                slice_res;

  // NOTE: always_comb assigns its output on every path, so no latch is inferred.
  always_comb begin
    slice_res = {1'b0, a_q[idx]} + {1'b0, b_q[idx]} + {{SLICE{1'b0}}, carry};
  end

  // NOTE: all state uses non-blocking assignments, so every register samples
  // its pre-edge values no matter in which order the statements are written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
      carry <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
      sum_q <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            // Subtract is done as A + ~B + 1, so only the add path is needed.
            a_q   <= a;
            b_q   <= op_sub ? ~b : b;
            carry <= op_sub ? 1'b1 : cin;
            idx   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          sum_q[idx] <= slice_res[SLICE-1:0];
          carry      <= slice_res[SLICE];
          if (idx == LAST_IDX) begin
            cout  <= slice_res[SLICE];
            ovf   <= (a_q[NSLICE-1][SLICE-1] == b_q[NSLICE-1][SLICE-1]) &
                     (slice_res[SLICE-1] != a_q[NSLICE-1][SLICE-1]);
            state <= DONE;
          end else begin
            idx <= idx + IDXW'(1);
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign sum       = sum_q;

endmodule

// File: tb/tb_add_slice_seq.sv
// Directed self-checking bench for add_slice_seq (WIDTH=64, SLICE=16).
module tb_add_slice_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] a;
  logic [63:0] b;
  logic        cin;
  logic        op_sub;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] sum;
  logic        cout;
  logic        ovf;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  add_slice_seq #(.WIDTH(64), .SLICE(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .op_sub    (op_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present a request on the falling edge; return 1 ns after the accepting edge.
  task automatic start_op(input logic [63:0] ta, input logic [63:0] tb, input logic tcin,
                          input logic tsub);
    @(negedge clk);
    a = ta; b = tb; cin = tcin; op_sub = tsub; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Count edges until out_valid, scrambling the operand inputs meanwhile.
  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      a = {$urandom, $urandom}; b = {$urandom, $urandom};
      cin = ~cin; op_sub = ~op_sub;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input logic [63:0] ta, input logic [63:0] tb,
                        input logic tcin, input logic tsub, input logic [63:0] exp_sum,
                        input logic exp_cout, input logic exp_ovf);
    int lat;
    out_ready = 1'b1;
    start_op(ta, tb, tcin, tsub);
    check({tag, "_busy"}, 64'(busy), 64'd1);
    wait_done(lat);
    check({tag, "_lat"}, 64'(lat), 64'd4);
    check({tag, "_sum"}, sum, exp_sum);
    check({tag, "_cout"}, 64'(cout), 64'(exp_cout));
    check({tag, "_ovf"}, 64'(ovf), 64'(exp_ovf));
    @(posedge clk); #1;
    check({tag, "_in_ready_after"}, 64'(in_ready), 64'd1);
    check({tag, "_out_valid_after"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    int lat;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; op_sub = 1'b0;
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_sum", sum, 64'd0);
    check("rst_cout", 64'(cout), 64'd0);
    check("rst_ovf", 64'(ovf), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_op("wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'd0, 1'b1, 1'b0);
    run_op("sub_borrow", 64'd5, 64'd7, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
    run_op("add_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0,
           64'h8000_0000_0000_0000, 1'b0, 1'b1);
    run_op("sub_ovf", 64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1,
           64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);

    // Async reset during the second RUN cycle, with cout/ovf/sum all nonzero.
    start_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("mid_run_busy", 64'(busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_busy", 64'(busy), 64'd0);
    check("async_rst_out_valid", 64'(out_valid), 64'd0);
    check("async_rst_sum", sum, 64'd0);
    check("async_rst_cout", 64'(cout), 64'd0);
    check("async_rst_ovf", 64'(ovf), 64'd0);
    check("async_rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("post_rst", 64'd3, 64'd4, 1'b0, 1'b0, 64'd7, 1'b0, 1'b0);

    run_op("carry_chain", 64'h0000_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0,
           64'h0001_0000_0000_0000, 1'b0, 1'b0);

    // Backpressure: result and handshake state held while out_ready=0.
    out_ready = 1'b0;
    start_op(64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b0, 1'b0);
    wait_done(lat);
    check("bp_lat", 64'(lat), 64'd4);
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      a = 64'd99; b = 64'd1;
      @(posedge clk); #1;
      check($sformatf("bp_out_valid_%0d", i), 64'(out_valid), 64'd1);
      check($sformatf("bp_in_ready_%0d", i), 64'(in_ready), 64'd0);
      check($sformatf("bp_sum_%0d", i), sum, 64'h1234_5678_9ABC_DF00);
      check($sformatf("bp_cout_%0d", i), 64'(cout), 64'd0);
    end
    in_valid = 1'b0;
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_in_ready", 64'(in_ready), 64'd1);
    check("bp_release_out_valid", 64'(out_valid), 64'd0);
    check("bp_release_busy", 64'(busy), 64'd0);
    check("bp_release_sum_kept", sum, 64'h1234_5678_9ABC_DF00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
